// File: rtl/fp_execute_stage3_pkg.sv
`default_nettype none
// ============================================================================
// fp_execute_stage3_pkg
// Shared types and constants for the fp_execute_stage3 slice.
// Revision: 1.0
// ============================================================================
package fp_execute_stage3_pkg;

  localparam int NUM_VECTOR_LANES = 16;
  localparam int THREADS_PER_CORE = 4;
  localparam int FP_GRS_WIDTH     = 3;
  localparam int FP_LZC_WIDTH     = 6;
  localparam int FP_SUM_WIDTH     = 33;

  typedef logic [31:0]                           scalar_t;
  typedef logic [NUM_VECTOR_LANES-1:0]           vector_mask_t;
  typedef logic [$clog2(NUM_VECTOR_LANES)-1:0]   subcycle_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0]   local_thread_idx_t;
  typedef logic [3:0]                            core_id_t;
  typedef logic [35:0]                           fp_ext_sig_t;

  typedef enum logic [1:0] {
    PIPE_MEM         = 2'd0,
    PIPE_INT_ARITH   = 2'd1,
    PIPE_FLOAT_ARITH = 2'd2
  } pipeline_sel_t;

  typedef enum logic [5:0] {
    OP_MULL_I = 6'b000111,
    OP_ADD_F  = 6'b100000,
    OP_SUB_F  = 6'b100001,
    OP_MUL_F  = 6'b100010,
    OP_FTOI   = 6'b100011
  } alu_op_t;

  typedef struct packed {
    logic          has_dest;
    logic          dest_is_vector;
    logic [4:0]    dest_reg;
    alu_op_t       alu_op;
    pipeline_sel_t pipeline_sel;
    logic          compare;
  } decoded_instruction_t;

  // Aligned significands on a 36-bit datapath: {spare, sig, g, r, s}.
  function automatic fp_ext_sig_t fp_ext_add(input scalar_t le, input scalar_t se,
                                             input logic [FP_GRS_WIDTH-1:0] grs,
                                             input logic subtract);
    fp_ext_sig_t a;
    fp_ext_sig_t b;
    a = {1'b0, le, 3'b000};
    b = {1'b0, se, grs};
    return subtract ? (a - b) : (a + b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_execute_stage3_lzc.sv
`default_nettype none
// ============================================================================
// fp_add_lzc
// Combinational leading-zero count of the 33-bit {carry, sum}; 33 when zero.
// Revision: 1.0
// ============================================================================
module fp_add_lzc
  import fp_execute_stage3_pkg::*;
(
  input  logic [FP_SUM_WIDTH-1:0] value,
  output logic [FP_LZC_WIDTH-1:0] lzc
);

  // Scan upward so the highest set bit writes last.
  always_comb begin
    lzc = FP_LZC_WIDTH'(FP_SUM_WIDTH);
    for (int i = 0; i < FP_SUM_WIDTH; i++) begin
      if (value[i])
        lzc = FP_LZC_WIDTH'(FP_SUM_WIDTH - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_execute_stage3.sv
`default_nettype none
// ============================================================================
// fp_execute_stage3
// FP stage 3: extended significand add/sub with GRS, leading-zero count, pass-through.
// Revision: 1.0
// ============================================================================
module fp_execute_stage3
  import fp_execute_stage3_pkg::*;
#(
  parameter core_id_t CORE_ID = '0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        wb_rollback_en,
  input  local_thread_idx_t                           wb_rollback_thread_idx,
  input  pipeline_sel_t                               wb_rollback_pipeline,
  input  logic                                        fx2_instruction_valid,
  input  decoded_instruction_t                        fx2_instruction,
  input  vector_mask_t                                fx2_mask_value,
  input  local_thread_idx_t                           fx2_thread_idx,
  input  subcycle_t                                   fx2_subcycle,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_result_inf,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_result_nan,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_result_equal,
  input  logic [NUM_VECTOR_LANES-1:0][5:0]            fx2_ftoi_lshift,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_logical_subtract,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_add_result_sign,
  input  logic [NUM_VECTOR_LANES-1:0][31:0]           fx2_significand_le,
  input  logic [NUM_VECTOR_LANES-1:0][31:0]           fx2_significand_se,
  input  logic [NUM_VECTOR_LANES-1:0][7:0]            fx2_add_exponent,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_guard,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_round,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_sticky,
  input  logic [NUM_VECTOR_LANES-1:0][63:0]           fx2_significand_product,
  input  logic [NUM_VECTOR_LANES-1:0][7:0]            fx2_mul_exponent,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_mul_underflow,
  input  logic [NUM_VECTOR_LANES-1:0]                 fx2_mul_sign,
  output logic                                        fx3_instruction_valid,
  output decoded_instruction_t                        fx3_instruction,
  output vector_mask_t                                fx3_mask_value,
  output local_thread_idx_t                           fx3_thread_idx,
  output subcycle_t                                   fx3_subcycle,
  output logic [NUM_VECTOR_LANES-1:0]                 fx3_result_inf,
  output logic [NUM_VECTOR_LANES-1:0]                 fx3_result_nan,
  output logic [NUM_VECTOR_LANES-1:0]                 fx3_result_equal,
  output logic [NUM_VECTOR_LANES-1:0][5:0]            fx3_ftoi_lshift,
  output logic [NUM_VECTOR_LANES-1:0]                 fx3_add_result_sign,
  output logic [NUM_VECTOR_LANES-1:0][7:0]            fx3_add_exponent,
  output logic [NUM_VECTOR_LANES-1:0]                 fx3_logical_subtract,
  output logic [NUM_VECTOR_LANES-1:0][32:0]           fx3_add_significand,
  output logic [NUM_VECTOR_LANES-1:0][FP_GRS_WIDTH-1:0] fx3_add_grs,
  output logic [NUM_VECTOR_LANES-1:0][FP_LZC_WIDTH-1:0] fx3_add_lzc,
  output logic [NUM_VECTOR_LANES-1:0][63:0]           fx3_significand_product,
  output logic [NUM_VECTOR_LANES-1:0][7:0]            fx3_mul_exponent,
  output logic [NUM_VECTOR_LANES-1:0]                 fx3_mul_underflow,
  output logic [NUM_VECTOR_LANES-1:0]                 fx3_mul_sign,
  output logic [NUM_VECTOR_LANES-1:0]                 fx3_mul_hibit
);

  localparam core_id_t c_core_id_unused = CORE_ID;

  logic w_squash;

  // Only a memory-pipeline rollback of this thread kills the slot.
  assign w_squash = wb_rollback_en && (wb_rollback_thread_idx == fx2_thread_idx)
                    && (wb_rollback_pipeline == PIPE_MEM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fx3_instruction_valid <= 1'b0;
      fx3_instruction       <= '0;
      fx3_mask_value        <= '0;
      fx3_thread_idx        <= '0;
      fx3_subcycle          <= '0;
      fx3_result_inf        <= '0;
      fx3_result_nan        <= '0;
      fx3_result_equal      <= '0;
      fx3_ftoi_lshift       <= '0;
      fx3_add_result_sign   <= '0;
      fx3_add_exponent      <= '0;
      fx3_logical_subtract  <= '0;
      fx3_mul_exponent      <= '0;
      fx3_mul_underflow     <= '0;
      fx3_mul_sign          <= '0;
    end else begin
      fx3_instruction_valid <= fx2_instruction_valid && !w_squash;
      fx3_instruction       <= fx2_instruction;
      fx3_mask_value        <= fx2_mask_value;
      fx3_thread_idx        <= fx2_thread_idx;
      fx3_subcycle          <= fx2_subcycle;
      fx3_result_inf        <= fx2_result_inf;
      fx3_result_nan        <= fx2_result_nan;
      fx3_result_equal      <= fx2_result_equal;
      fx3_ftoi_lshift       <= fx2_ftoi_lshift;
      fx3_add_result_sign   <= fx2_add_result_sign;
      fx3_add_exponent      <= fx2_add_exponent;
      fx3_logical_subtract  <= fx2_logical_subtract;
      fx3_mul_exponent      <= fx2_mul_exponent;
      fx3_mul_underflow     <= fx2_mul_underflow;
      fx3_mul_sign          <= fx2_mul_sign;
    end
  end

  for (genvar lane = 0; lane < NUM_VECTOR_LANES; lane++) begin : g_lane
    fp_ext_sig_t             w_result;
    logic [FP_LZC_WIDTH-1:0] w_lzc;

    assign w_result = fp_ext_add(fx2_significand_le[lane], fx2_significand_se[lane],
                                 {fx2_guard[lane], fx2_round[lane], fx2_sticky[lane]},
                                 fx2_logical_subtract[lane]);

    fp_add_lzc u_lzc (
      .value(w_result[35:FP_GRS_WIDTH]),
      .lzc  (w_lzc)
    );

    always_ff @(posedge clk) begin
      if (!reset) begin
        fx3_add_significand[lane]     <= '0;
        fx3_add_grs[lane]             <= '0;
        fx3_add_lzc[lane]             <= '0;
        fx3_significand_product[lane] <= '0;
        fx3_mul_hibit[lane]           <= 1'b0;
      end else begin
        fx3_add_significand[lane]     <= w_result[35:FP_GRS_WIDTH];
        fx3_add_grs[lane]             <= w_result[FP_GRS_WIDTH-1:0];
        fx3_add_lzc[lane]             <= w_lzc;
        fx3_significand_product[lane] <= fx2_significand_product[lane];
        fx3_mul_hibit[lane]           <= fx2_significand_product[lane][47];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_execute_stage3.sv
`default_nettype none
// ============================================================================
// tb_fp_execute_stage3
// Directed self-checking bench for fp_execute_stage3.
// Revision: 1.0
// ============================================================================
module tb_fp_execute_stage3;
  import fp_execute_stage3_pkg::*;

  localparam int L = NUM_VECTOR_LANES;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     wb_rollback_en;
  local_thread_idx_t        wb_rollback_thread_idx;
  pipeline_sel_t            wb_rollback_pipeline;
  logic                     fx2_instruction_valid;
  decoded_instruction_t     fx2_instruction;
  vector_mask_t             fx2_mask_value;
  local_thread_idx_t        fx2_thread_idx;
  subcycle_t                fx2_subcycle;
  logic [L-1:0]             fx2_result_inf, fx2_result_nan, fx2_result_equal;
  logic [L-1:0][5:0]        fx2_ftoi_lshift;
  logic [L-1:0]             fx2_logical_subtract, fx2_add_result_sign;
  logic [L-1:0][31:0]       fx2_significand_le, fx2_significand_se;
  logic [L-1:0][7:0]        fx2_add_exponent;
  logic [L-1:0]             fx2_guard, fx2_round, fx2_sticky;
  logic [L-1:0][63:0]       fx2_significand_product;
  logic [L-1:0][7:0]        fx2_mul_exponent;
  logic [L-1:0]             fx2_mul_underflow, fx2_mul_sign;

  logic                     fx3_instruction_valid;
  decoded_instruction_t     fx3_instruction;
  vector_mask_t             fx3_mask_value;
  local_thread_idx_t        fx3_thread_idx;
  subcycle_t                fx3_subcycle;
  logic [L-1:0]             fx3_result_inf, fx3_result_nan, fx3_result_equal;
  logic [L-1:0][5:0]        fx3_ftoi_lshift;
  logic [L-1:0]             fx3_add_result_sign;
  logic [L-1:0][7:0]        fx3_add_exponent;
  logic [L-1:0]             fx3_logical_subtract;
  logic [L-1:0][32:0]       fx3_add_significand;
  logic [L-1:0][2:0]        fx3_add_grs;
  logic [L-1:0][5:0]        fx3_add_lzc;
  logic [L-1:0][63:0]       fx3_significand_product;
  logic [L-1:0][7:0]        fx3_mul_exponent;
  logic [L-1:0]             fx3_mul_underflow, fx3_mul_sign, fx3_mul_hibit;

  int n_checks = 0;
  int n_fail   = 0;

  fp_execute_stage3 #(.CORE_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
    .wb_rollback_pipeline(wb_rollback_pipeline),
    .fx2_instruction_valid(fx2_instruction_valid), .fx2_instruction(fx2_instruction),
    .fx2_mask_value(fx2_mask_value), .fx2_thread_idx(fx2_thread_idx), .fx2_subcycle(fx2_subcycle),
    .fx2_result_inf(fx2_result_inf), .fx2_result_nan(fx2_result_nan),
    .fx2_result_equal(fx2_result_equal), .fx2_ftoi_lshift(fx2_ftoi_lshift),
    .fx2_logical_subtract(fx2_logical_subtract), .fx2_add_result_sign(fx2_add_result_sign),
    .fx2_significand_le(fx2_significand_le), .fx2_significand_se(fx2_significand_se),
    .fx2_add_exponent(fx2_add_exponent), .fx2_guard(fx2_guard), .fx2_round(fx2_round),
    .fx2_sticky(fx2_sticky), .fx2_significand_product(fx2_significand_product),
    .fx2_mul_exponent(fx2_mul_exponent), .fx2_mul_underflow(fx2_mul_underflow),
    .fx2_mul_sign(fx2_mul_sign),
    .fx3_instruction_valid(fx3_instruction_valid), .fx3_instruction(fx3_instruction),
    .fx3_mask_value(fx3_mask_value), .fx3_thread_idx(fx3_thread_idx), .fx3_subcycle(fx3_subcycle),
    .fx3_result_inf(fx3_result_inf), .fx3_result_nan(fx3_result_nan),
    .fx3_result_equal(fx3_result_equal), .fx3_ftoi_lshift(fx3_ftoi_lshift),
    .fx3_add_result_sign(fx3_add_result_sign), .fx3_add_exponent(fx3_add_exponent),
    .fx3_logical_subtract(fx3_logical_subtract), .fx3_add_significand(fx3_add_significand),
    .fx3_add_grs(fx3_add_grs), .fx3_add_lzc(fx3_add_lzc),
    .fx3_significand_product(fx3_significand_product), .fx3_mul_exponent(fx3_mul_exponent),
    .fx3_mul_underflow(fx3_mul_underflow), .fx3_mul_sign(fx3_mul_sign),
    .fx3_mul_hibit(fx3_mul_hibit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_add(input int lane, input logic [31:0] le, input logic [31:0] se,
                         input logic [2:0] grs, input logic sub);
    fx2_significand_le[lane]   = le;
    fx2_significand_se[lane]   = se;
    {fx2_guard[lane], fx2_round[lane], fx2_sticky[lane]} = grs;
    fx2_logical_subtract[lane] = sub;
  endtask

  initial begin
    reset = 1'b0;
    wb_rollback_en = 1'b0; wb_rollback_thread_idx = '0; wb_rollback_pipeline = PIPE_MEM;
    fx2_instruction_valid = 1'b1; fx2_instruction = '0; fx2_mask_value = 16'hFFFF;
    fx2_thread_idx = 2'd3; fx2_subcycle = 4'd5;
    fx2_result_inf = '1; fx2_result_nan = '0; fx2_result_equal = '0; fx2_ftoi_lshift = '0;
    fx2_logical_subtract = '0; fx2_add_result_sign = '0;
    fx2_significand_le = '0; fx2_significand_se = '0; fx2_add_exponent = '0;
    fx2_guard = '0; fx2_round = '0; fx2_sticky = '0;
    fx2_significand_product = '0; fx2_mul_exponent = '0;
    fx2_mul_underflow = '0; fx2_mul_sign = '0;
    fx2_significand_product[0] = 64'hFFFF_FFFF_FFFF_FFFF;

    // Live-looking inputs held during reset must not leak through.
    tick(); tick();
    check("reset_valid",   64'(fx3_instruction_valid), 64'd0);
    check("reset_mask",    64'(fx3_mask_value), 64'd0);
    check("reset_inf",     64'(fx3_result_inf), 64'd0);
    check("reset_lzc0",    64'(fx3_add_lzc[0]), 64'd0);
    check("reset_product", fx3_significand_product[0], 64'd0);
    check("reset_hibit",   64'(fx3_mul_hibit[0]), 64'd0);

    // Adder vectors, one per lane.
    reset = 1'b1;
    fx2_result_inf = '0; fx2_significand_product[0] = '0;
    fx2_thread_idx = 2'd2; fx2_mask_value = 16'hA5A5; fx2_add_exponent[0] = 8'h7F;
    fx2_instruction.alu_op = OP_ADD_F;
    set_add(0, 32'h0080_0000, 32'h0040_0000, 3'b000, 1'b0);
    set_add(1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 1'b0);
    set_add(2, 32'h0080_0000, 32'h0080_0000, 3'b000, 1'b1);
    set_add(3, 32'h0080_0001, 32'h007F_FFFF, 3'b100, 1'b1);
    tick();
    check("add_valid",  64'(fx3_instruction_valid), 64'd1);
    check("add_thread", 64'(fx3_thread_idx), 64'd2);
    check("add_mask",   64'(fx3_mask_value), 64'hA5A5);
    check("add_exp0",   64'(fx3_add_exponent[0]), 64'h7F);
    check("sig0", 64'(fx3_add_significand[0]), 64'h0_00C0_0000);
    check("grs0", 64'(fx3_add_grs[0]), 64'd0);
    check("lzc0", 64'(fx3_add_lzc[0]), 64'd9);
    check("sig1", 64'(fx3_add_significand[1]), 64'h1_0000_0000);
    check("grs1", 64'(fx3_add_grs[1]), 64'd5);
    check("lzc1", 64'(fx3_add_lzc[1]), 64'd0);
    check("sig2", 64'(fx3_add_significand[2]), 64'd0);
    check("grs2", 64'(fx3_add_grs[2]), 64'd0);
    check("lzc2", 64'(fx3_add_lzc[2]), 64'd33);
    check("sig3", 64'(fx3_add_significand[3]), 64'd1);
    check("grs3", 64'(fx3_add_grs[3]), 64'd4);
    check("lzc3", 64'(fx3_add_lzc[3]), 64'd32);
    check("sub3_flag", 64'(fx3_logical_subtract[3]), 64'd1);

    // Rollback squash cases on thread 2.
    wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd2; wb_rollback_pipeline = PIPE_MEM;
    tick();
    check("rb_match", 64'(fx3_instruction_valid), 64'd0);
    wb_rollback_thread_idx = 2'd1;
    tick();
    check("rb_other_thread", 64'(fx3_instruction_valid), 64'd1);
    wb_rollback_thread_idx = 2'd2; wb_rollback_pipeline = PIPE_FLOAT_ARITH;
    tick();
    check("rb_other_pipe", 64'(fx3_instruction_valid), 64'd1);
    wb_rollback_en = 1'b0; wb_rollback_pipeline = PIPE_MEM;
    fx2_instruction_valid = 1'b0;
    tick();
    check("idle_slot", 64'(fx3_instruction_valid), 64'd0);

    // Product pass-through and hibit.
    fx2_instruction_valid = 1'b1;
    fx2_instruction.alu_op = OP_MUL_F;
    fx2_significand_product[0] = 64'h0000_8000_0000_0000;
    fx2_significand_product[5] = 64'h0000_7FFF_FFFF_FFFF;
    fx2_mul_exponent[0] = 8'h85; fx2_mul_sign[0] = 1'b1;
    tick();
    check("mul_product0", fx3_significand_product[0], 64'h0000_8000_0000_0000);
    check("mul_hibit0",   64'(fx3_mul_hibit[0]), 64'd1);
    check("mul_product5", fx3_significand_product[5], 64'h0000_7FFF_FFFF_FFFF);
    check("mul_hibit5",   64'(fx3_mul_hibit[5]), 64'd0);
    check("mul_exp0",     64'(fx3_mul_exponent[0]), 64'h85);
    check("mul_sign0",    64'(fx3_mul_sign[0]), 64'd1);
    check("mul_op",       64'(fx3_instruction.alu_op), 64'(OP_MUL_F));

    // Mid-flight reset discards the slot; next input flows normally.
    reset = 1'b0;
    tick();
    check("midrst_valid",   64'(fx3_instruction_valid), 64'd0);
    check("midrst_product", fx3_significand_product[0], 64'd0);
    check("midrst_sig1",    64'(fx3_add_significand[1]), 64'd0);
    check("midrst_instr",   64'(fx3_instruction), 64'd0);
    check("midrst_thread",  64'(fx3_thread_idx), 64'd0);
    reset = 1'b1;
    tick();
    check("post_valid",   64'(fx3_instruction_valid), 64'd1);
    check("post_product", fx3_significand_product[0], 64'h0000_8000_0000_0000);
    check("post_sig1",    64'(fx3_add_significand[1]), 64'h1_0000_0000);
    check("post_subcyc",  64'(fx3_subcycle), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
